// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue queue: data/opcode widths, the legal
// opcode set, the queue entry layout and the output-stage state encoding.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int OP_W      = 3;
  // Tags narrower than this are zero-extended into the entry.
  localparam int TAG_W_MAX = 8;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_LT  = 3'b011;

  typedef struct packed {
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [OP_W-1:0]      opcode;
    logic [TAG_W_MAX-1:0] tag;
  } alu_entry_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Generic DEPTH-entry synchronous FIFO. Head is read combinationally from
// the storage registers. Push while full and pop while empty are ignored.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   push, push_data     write request and data
//   pop                 remove head entry
//   head_data           current head (undefined when count == 0)
//   count               occupancy, 0..DEPTH
module alu_issue_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != CNT_W'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/alu_issue_queue.sv
// Operand staging and result capture around a combinational 32-bit ALU.
// Tagged ops are queued in a DEPTH-entry FIFO; the head drives the ALU and
// the ALU result is captured with its tag into a registered output slot.
// Optional feature macro: ALU_ISSUE_OPCHECK_EN (illegal-opcode trapping).
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready, in_a/b/opcode/tag   upstream op handshake
//   alu_a/b/opcode, alu_result          to/from the combinational ALU
//   out_valid/out_ready, out_result/tag/err downstream result handshake
//   count                               FIFO occupancy
//
// Output stage states:
//   state     | meaning
//   OUT_EMPTY | no result held, out_valid = 0
//   OUT_FULL  | result held, out_valid = 1, fields stable until accepted
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_a,
  input  logic [31:0]            in_b,
  input  logic [2:0]             in_opcode,
  input  logic [TAG_W-1:0]       in_tag,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_opcode,
  input  logic [31:0]            alu_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  alu_entry_t          in_entry, head_entry;
  logic                head_valid, head_illegal;
  logic                push, fire;

  out_state_e          state_q, state_d;
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;
  logic                out_err_q, out_err_d;
  logic                unused_tag_hi;

  assign in_entry = '{a: in_a, b: in_b, opcode: in_opcode, tag: TAG_W_MAX'(in_tag)};

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(alu_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_entry),
    .pop       (fire),
    .head_data (head_entry),
    .count     (count)
  );

  // in_ready comes from registered occupancy only; a slot freed by this
  // cycle's fire is not offered until the next cycle.
  assign in_ready   = (count != CNT_W'(DEPTH));
  assign push       = in_valid && in_ready;
  assign head_valid = (count != '0);
  assign fire       = head_valid && ((state_q == OUT_EMPTY) || out_ready);

`ifdef ALU_ISSUE_OPCHECK_EN
  assign head_illegal = head_valid && !op_legal(head_entry.opcode);
`else
  assign head_illegal = 1'b0;
`endif

  assign alu_a      = head_valid ? head_entry.a : '0;
  assign alu_b      = head_valid ? head_entry.b : '0;
  assign alu_opcode = (head_valid && !head_illegal) ? head_entry.opcode : OP_ADD;

  // Upper tag bits are always zero when TAG_W < TAG_W_MAX.
  assign unused_tag_hi = ^head_entry.tag;

  always_comb begin
    state_d      = state_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;
    if (fire) begin
      state_d      = OUT_FULL;
      out_result_d = head_illegal ? '0 : alu_result;
      out_tag_d    = head_entry.tag[TAG_W-1:0];
      out_err_d    = head_illegal;
    end else if ((state_q == OUT_FULL) && out_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OUT_EMPTY;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
    end
  end

  assign out_valid  = (state_q == OUT_FULL);
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: a directed vector table, hand sequences for
// reset/illegal-opcode corners, then randomized traffic, all compared
// against a queue-based reference model.
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_opcode;
  logic [3:0]  in_tag;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [2:0]  count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .in_tag     (in_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err),
    .count      (count)
  );

  // Stand-in combinational ALU.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return a << b[4:0];
      default: return ~a;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_opcode);

  // Reference model: a plain queue of pending ops plus one held result.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
  } op_t;

  op_t         mq[$];
  bit          m_has = 0;
  logic [31:0] m_res = '0;
  logic [3:0]  m_tag = '0;
  bit          m_err = 0;

  function automatic bit is_illegal(input logic [2:0] op);
`ifdef ALU_ISSUE_OPCHECK_EN
    return !(op == 3'd0 || op == 3'd1 || op == 3'd3);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] exp_op(input logic [2:0] op);
    return is_illegal(op) ? 3'd0 : op;
  endfunction

  function automatic logic [31:0] exp_res(input op_t o);
    return is_illegal(o.op) ? 32'd0 : alu_fn(o.a, o.b, o.op);
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_edge(input bit iv, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op, input logic [3:0] tag, input bit ordy);
    op_t h;
    op_t n;
    bit  fire;
    bit  push;
    fire = (mq.size() != 0) && (!m_has || ordy);
    push = iv && (mq.size() < DEPTH);
    if (fire) begin
      h     = mq.pop_front();
      m_res = exp_res(h);
      m_tag = h.tag;
      m_err = is_illegal(h.op);
      m_has = 1;
    end else if (m_has && ordy) begin
      m_has = 0;
    end
    if (push) begin
      n.a = a; n.b = b; n.op = op; n.tag = tag;
      mq.push_back(n);
    end
  endtask

  task automatic check_model();
    chk("out_valid", 32'(out_valid), 32'(m_has));
    if (m_has) begin
      chk("out_result", out_result, m_res);
      chk("out_tag", 32'(out_tag), 32'(m_tag));
      chk("out_err", 32'(out_err), 32'(m_err));
    end
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    if (mq.size() != 0) begin
      chk("alu_a", alu_a, mq[0].a);
      chk("alu_b", alu_b, mq[0].b);
      chk("alu_opcode", 32'(alu_opcode), 32'(exp_op(mq[0].op)));
    end else begin
      chk("alu_a_idle", alu_a, 32'd0);
      chk("alu_b_idle", alu_b, 32'd0);
      chk("alu_opcode_idle", 32'(alu_opcode), 32'd0);
    end
  endtask

  // Entered just after a falling edge; returns just after the next one.
  task automatic step(input bit iv, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] op, input logic [3:0] tag, input bit ordy);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    in_tag    = tag;
    out_ready = ordy;
    @(posedge clk);
    model_edge(iv, a, b, op, tag, ordy);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    int iv; int a; int b; int op; int tag; int ordy;
    int e_valid; int e_res; int e_tag; int e_count; int e_rdy;
  } vec_t;

  vec_t vt[17];

  initial begin
    //           iv  a  b op tag rdy  ev  res          etag cnt rdy
    vt[0]  = '{1, 5, 3, 0, 1, 1,  0, 0,            0, 1, 1};
    vt[1]  = '{0, 0, 0, 0, 0, 1,  1, 8,            1, 0, 1};
    vt[2]  = '{1, 3, 5, 1, 2, 1,  0, 0,            0, 1, 1};
    vt[3]  = '{1, 3, 5, 3, 3, 1,  1, 32'hFFFF_FFFE, 2, 1, 1};
    vt[4]  = '{0, 0, 0, 0, 0, 1,  1, 1,            3, 0, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 1,  0, 0,            0, 0, 1};
    vt[6]  = '{1, 1, 1, 0, 4, 0,  0, 0,            0, 1, 1};
    vt[7]  = '{1, 2, 2, 0, 5, 0,  1, 2,            4, 1, 1};
    vt[8]  = '{1, 3, 3, 0, 6, 0,  1, 2,            4, 2, 1};
    vt[9]  = '{1, 4, 4, 0, 7, 0,  1, 2,            4, 3, 1};
    vt[10] = '{1, 5, 5, 0, 8, 0,  1, 2,            4, 4, 0};
    vt[11] = '{1, 6, 6, 0, 9, 0,  1, 2,            4, 4, 0};
    vt[12] = '{0, 0, 0, 0, 0, 1,  1, 4,            5, 3, 1};
    vt[13] = '{0, 0, 0, 0, 0, 1,  1, 6,            6, 2, 1};
    vt[14] = '{0, 0, 0, 0, 0, 1,  1, 8,            7, 1, 1};
    vt[15] = '{0, 0, 0, 0, 0, 1,  1, 10,           8, 0, 1};
    vt[16] = '{0, 0, 0, 0, 0, 1,  0, 0,            0, 0, 1};

    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd11;
    in_b      = 32'd22;
    in_opcode = 3'd1;
    in_tag    = 4'd3;
    out_ready = 1'b1;

    // Held in reset with in_valid asserted: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Directed table: basic ops, stall/fill to full, ordered drain.
    for (int i = 0; i < 17; i++) begin
      step(vt[i].iv[0], 32'(vt[i].a), 32'(vt[i].b), 3'(vt[i].op), 4'(vt[i].tag),
           vt[i].ordy[0]);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vt[i].e_valid));
      if (vt[i].e_valid != 0) begin
        chk($sformatf("vec%0d_result", i), out_result, 32'(vt[i].e_res));
        chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vt[i].e_tag));
      end
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].e_count));
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
    end

    // Illegal opcode 111 with tag 7.
    step(1'b1, 32'd9, 32'd2, 3'd7, 4'd7, 1'b1);
`ifdef ALU_ISSUE_OPCHECK_EN
    chk("illegal_alu_opcode", 32'(alu_opcode), 32'd0);
`else
    chk("illegal_alu_opcode", 32'(alu_opcode), 32'd7);
`endif
    step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b1);
    chk("illegal_tag", 32'(out_tag), 32'd7);
`ifdef ALU_ISSUE_OPCHECK_EN
    chk("illegal_err", 32'(out_err), 32'd1);
    chk("illegal_result", out_result, 32'd0);
`else
    chk("illegal_err", 32'(out_err), 32'd0);
    chk("illegal_result", out_result, ~32'd9);
`endif
    step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b1);

    // Build count=3 with a held result, then reset asynchronously.
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'(100 + i), 32'(i), 3'd0, 4'(10 + i), 1'b0);
    chk("preburst_count", 32'(count), 32'd3);
    chk("preburst_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_result", out_result, 32'd0);
    chk("midrst_out_tag", 32'(out_tag), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    m_has = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'd7, 32'd8, 3'd0, 4'hA, 1'b1);
    step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b1);
    chk("postrst_result", out_result, 32'd15);
    chk("postrst_tag", 32'(out_tag), 32'hA);
    step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b1);
    chk("postrst_empty", 32'(count), 32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom(), $urandom(),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
           $urandom_range(0, 9) < 6);
    end
    for (int i = 0; i < 8; i++)
      step(1'b0, 32'd0, 32'd0, 3'd0, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Operand staging and result capture stage for the 32-bit ALU. Accepts tagged operations (A, B, opcode) over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and drives the head entry onto the combinational ALU's A/B/opcode inputs. It registers the ALU result with its tag and error flag into an output stage with its own valid/ready handshake. Sits directly upstream of the ALU and wraps its result path, giving the ALU a registered, back-pressurable pipeline slot.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 4, width of the tag carried alongside each operation

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream operation valid
- in_ready  output  1  queue can accept; equals (count != DEPTH)
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_opcode  input  3  ALU opcode
- in_tag  input  TAG_W  tag returned with the result
- alu_a  output  32  to ALU A; FIFO head A, or 0 when empty
- alu_b  output  32  to ALU B; FIFO head B, or 0 when empty
- alu_opcode  output  3  to ALU opcode; FIFO head opcode, or 3'b000 when empty
- alu_result  input  32  combinational result from ALU
- out_valid  output  1  registered result valid
- out_ready  input  1  downstream accepts result
- out_result  output  32  registered result
- out_tag  output  TAG_W  tag of registered result
- out_err  output  1  illegal-opcode flag (see Configuration)
- count  output  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Push: in_valid && in_ready stores {a, b, opcode, tag} at the write pointer. The write pointer increments and wraps modulo DEPTH.
- Output stage states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Issue: fire = (count != 0) && (!out_valid || out_ready).
- On fire, the output register captures alu_result, the head tag and the error flag, the read pointer increments modulo DEPTH, and the state becomes FULL.
- Drain: out_valid && out_ready && !fire → EMPTY.
- Drain and fire in the same cycle: stay FULL and load the new result (back-to-back throughput 1/cycle).
- Simultaneous push and fire: count unchanged. Push alone: count+1. Fire alone: count−1.
- Stall: while out_valid && !out_ready, out_result, out_tag and out_err stay stable and no fire occurs. The FIFO keeps accepting until full.
- Full: in_ready=0 and any push attempt is ignored. There is no combinational out_ready→in_ready path.
- The result width is 32 bits. The tag and opcode travel unmodified.

## Timing
- Reset (rst_n low, asynchronous): pointers and count = 0, out_valid = 0, and out_result, out_tag, out_err = 0.
- While count=0: in_ready = 1, alu_a and alu_b = 0, alu_opcode = 000.
- Reset mid-operation discards all queued and registered entries.
- Minimum latency: an operation accepted at edge N appears on alu_* in cycle N+1 and on out_valid in cycle N+2.
- Sustained throughput: one operation per cycle when out_ready stays high.
- alu_* outputs depend only on registered FIFO state, with no input-to-ALU combinational path.

## Configuration
- Macro: ALU_ISSUE_OPCHECK_EN.
- Defined: legal opcodes are 000 (add), 001 (sub) and 011 (lt). An illegal head opcode drives alu_opcode = 000, is captured with out_result = 0 and out_err = 1, and still consumes one slot and returns its tag.
- Undefined: the opcode passes through unchanged, out_result = alu_result, and out_err is tied 0.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_ADD=3'b000, OP_SUB=3'b001, OP_LT=3'b011
  - data width constant 32
  - packed struct type for a queue entry {a, b, opcode, tag}
- One sub-module, alu_issue_fifo: a generic DEPTH-entry synchronous FIFO with push, pop, head and count. The top level holds the output register and the issue logic.

## Test plan
- Reset with in_valid=1 asserted → out_valid=0, count=0, in_ready=1 and alu_opcode=000 throughout reset.
- Push {A=5, B=3, op=000, tag=1} with out_ready=1 → out_valid in cycle N+2 with out_result=8, out_tag=1.
- Push op=001 with A=3, B=5, tag=2 → out_result=0xFFFFFFFE. Then push op=011 with A=3, B=5, tag=3 → out_result=1.
- Hold out_ready=0 and push 5 ops at DEPTH=4:
  - expected: the first op goes to the output stage and 4 fill the FIFO, then in_ready=0 with count=4 and the 6th push is ignored.
  - then release out_ready: results emerge in order, one per cycle.
- With the macro defined, push op=111, tag=7 → out_err=1, out_result=0, out_tag=7. With the macro undefined → out_err=0.
- Deassert rst_n mid-burst with count=3 and out_valid=1 → outputs zero immediately. After release, a fresh push returns the correct result with no stale entries.
